// File: rtl/program_loader_memory_pkg.sv
// Shared types and constants for the program loader memory.
// NOP_INST may be supplied externally; it defaults to an all-zero word.
`ifndef NOP_INST
`define NOP_INST 16'h0000
`endif

package loader_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    ERROR = 2'd2,
    CHECK = 2'd3
  } state_t;

  localparam int unsigned INSTR_WIDTH_DEF = 16;
  localparam int unsigned BYTES_PER_WORD  = INSTR_WIDTH_DEF / 8;
  localparam logic [INSTR_WIDTH_DEF-1:0] NOP_WORD = `NOP_INST;

  // Bits needed to index n items, never less than one.
  function automatic int unsigned bits_for(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/program_loader_memory_if.sv
// Byte-stream loader handshake between a program source (master) and the loader (slave).
interface program_loader_memory_if;
  logic       load_valid;
  logic       load_ready;
  logic [7:0] load_byte;
  logic       load_last;

  modport master (output load_valid, output load_byte, output load_last, input load_ready);
  modport slave  (input load_valid, input load_byte, input load_last, output load_ready);
endinterface

// File: rtl/program_loader_memory_byte_assembler.sv
// Packs an MSB-first byte stream into instruction words; zero-pads a word cut short by last.
module byte_assembler
  import loader_pkg::*;
#(
  parameter int unsigned INSTR_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   accept,
  input  logic [7:0]             data_byte,
  input  logic                   last,
  output logic                   word_done,
  output logic [INSTR_WIDTH-1:0] word
);

  localparam int unsigned BPW = INSTR_WIDTH / 8;
  localparam int unsigned PW  = bits_for(BPW);

  logic [PW-1:0]          byte_phase;
  logic [INSTR_WIDTH-1:0] asm_q;

  // Later bytes land in still-zero slots, so an early last needs no explicit padding.
  always_comb begin
    word = asm_q;
    for (int unsigned k = 0; k < BPW; k++) begin
      if (byte_phase == PW'(k)) word[INSTR_WIDTH-1-8*k -: 8] = data_byte;
    end
  end

  assign word_done = accept && (last || (byte_phase == PW'(BPW - 1)));

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      byte_phase <= '0;
      asm_q      <= '0;
    end else if (accept) begin
      if (word_done) begin
        byte_phase <= '0;
        asm_q      <= '0;
      end else begin
        byte_phase <= byte_phase + 1'b1;
        asm_q      <= word;
      end
    end
  end

endmodule

// File: rtl/program_loader_memory.sv
// Instruction store with byte-stream loader FSM; gates the core until a program is loaded.
// Optional trailing checksum byte: define LOADER_CHECKSUM_EN.
module program_loader_memory
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned INSTR_WIDTH = 16,
  parameter int unsigned DEPTH       = 1024
) (
  input  logic                     clock,
  input  logic                     reset,
  program_loader_memory_if.slave   lif,
  input  logic                     reload,
  input  logic [ADDR_WIDTH-1:0]    pc,
  output logic [INSTR_WIDTH-1:0]   instruction,
  output logic                     core_run,
  output logic [ADDR_WIDTH:0]      word_count,
  output logic                     load_error
);

  localparam int unsigned IDX_W = bits_for(DEPTH);
  localparam logic [INSTR_WIDTH-1:0] NOP = INSTR_WIDTH'(NOP_WORD);

  state_t                 state_q, state_d;
  logic                   accept, asm_accept, reload_go, word_done, at_last_addr;
  logic [INSTR_WIDTH-1:0] word;
  logic [INSTR_WIDTH-1:0] mem [DEPTH];

  assign accept       = lif.load_valid && lif.load_ready;
  assign asm_accept   = accept && (state_q == LOAD);
  assign reload_go    = reload && ((state_q == RUN) || (state_q == ERROR));
  assign at_last_addr = (word_count == (ADDR_WIDTH+1)'(DEPTH - 1));
  assign core_run     = (state_q == RUN);

  byte_assembler #(.INSTR_WIDTH(INSTR_WIDTH)) u_asm (
    .clock     (clock),
    .reset     (reset),
    .clear     (reload_go),
    .accept    (asm_accept),
    .data_byte (lif.load_byte),
    .last      (lif.load_last),
    .word_done (word_done),
    .word      (word)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum_q;

  always_ff @(posedge clock) begin
    if (reset || reload_go) csum_q <= '0;
    else if (asm_accept)    csum_q <= csum_q ^ lif.load_byte;
  end

  assign lif.load_ready = (state_q == LOAD) || (state_q == CHECK);
`else
  assign lif.load_ready = (state_q == LOAD);
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD: begin
        if (asm_accept && lif.load_last) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = RUN;
`endif
        end else if (word_done && at_last_addr) begin
          state_d = ERROR;
        end
      end
      CHECK: begin
`ifdef LOADER_CHECKSUM_EN
        if (accept) state_d = (lif.load_byte == csum_q) ? RUN : ERROR;
`else
        state_d = LOAD;
`endif
      end
      RUN, ERROR: if (reload) state_d = LOAD;
      default:    state_d = LOAD;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= LOAD;
      word_count <= '0;
      load_error <= 1'b0;
    end else begin
      state_q <= state_d;
      if (reload_go) begin
        word_count <= '0;
        load_error <= 1'b0;
      end else begin
        if (word_done) word_count <= word_count + 1'b1;
        if ((state_d == ERROR) && (state_q != ERROR)) load_error <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (word_done) mem[word_count[IDX_W-1:0]] <= word;
  end

  // pc < word_count <= DEPTH keeps the truncated index in range whenever it is used.
  assign instruction = (core_run && ({1'b0, pc} < word_count)) ? mem[pc[IDX_W-1:0]] : NOP;

endmodule

// File: tb/tb_program_loader_memory.sv
// Scoreboard bench for program_loader_memory (DEPTH=4); also covers LOADER_CHECKSUM_EN builds.
module tb_program_loader_memory;
  import loader_pkg::*;

  localparam int unsigned AW = 10;
  localparam int unsigned IW = 16;
  localparam int unsigned DP = 4;
  localparam logic [IW-1:0] NOP = NOP_WORD;

  logic          clock = 1'b0;
  logic          reset;
  logic          reload;
  logic [AW-1:0] pc;
  logic [IW-1:0] instruction;
  logic          core_run;
  logic [AW:0]   word_count;
  logic          load_error;

  program_loader_memory_if lif ();

  program_loader_memory #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .DEPTH(DP)) dut (
    .clock       (clock),
    .reset       (reset),
    .lif         (lif),
    .reload      (reload),
    .pc          (pc),
    .instruction (instruction),
    .core_run    (core_run),
    .word_count  (word_count),
    .load_error  (load_error)
  );

  always #5 clock = ~clock;

  typedef enum int {K_INSTR, K_WC, K_RUN, K_READY, K_ERR} kind_t;
  typedef struct {
    string       name;
    kind_t       kind;
    logic [31:0] value;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  logic [31:0] act;
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  tb_csum = 8'h00;

  always @(negedge clock) begin
    while (sb.size() > 0) begin
      cur = sb.pop_front();
      case (cur.kind)
        K_INSTR: act = 32'(instruction);
        K_WC:    act = 32'(word_count);
        K_RUN:   act = 32'(core_run);
        K_READY: act = 32'(lif.load_ready);
        default: act = 32'(load_error);
      endcase
      checks++;
      if (act !== cur.value) begin
        errors++;
        $display("FAIL %s: got %0h, expected %0h", cur.name, act, cur.value);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_exp(input string name, input kind_t k, input logic [31:0] v);
    exp_t e;
    e.name  = name;
    e.kind  = k;
    e.value = v;
    sb.push_back(e);
  endtask

  task automatic status(input string tag, input bit run, input bit rdy, input bit err, input int wc);
    push_exp({tag, "/core_run"},   K_RUN,   32'(run));
    push_exp({tag, "/load_ready"}, K_READY, 32'(rdy));
    push_exp({tag, "/load_error"}, K_ERR,   32'(err));
    push_exp({tag, "/word_count"}, K_WC,    32'(wc));
    step();
  endtask

  task automatic fetch(input string tag, input logic [AW-1:0] a, input logic [IW-1:0] v);
    pc = a;
    push_exp(tag, K_INSTR, 32'(v));
    step();
  endtask

  task automatic send(input logic [7:0] b, input bit last);
    int unsigned waited = 0;
    bit          timed_out = 1'b0;
    lif.load_valid = 1'b1;
    lif.load_byte  = b;
    lif.load_last  = last;
    forever begin
      @(negedge clock);
      if (lif.load_ready) break;
      waited++;
      if (waited > 20) begin
        timed_out = 1'b1;
        break;
      end
    end
    if (timed_out) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: load_ready low for %0d cycles, expected high", waited);
    end else begin
      tb_csum = tb_csum ^ b;
    end
    @(posedge clock);
    #1;
    lif.load_valid = 1'b0;
    lif.load_last  = 1'b0;
  endtask

  task automatic end_program();
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] c;
    c = tb_csum;
    send(c, 1'b0);
`endif
    tb_csum = 8'h00;
  endtask

  task automatic do_reload();
    reload = 1'b1;
    step();
    reload  = 1'b0;
    tb_csum = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  initial begin
    reset          = 1'b1;
    reload         = 1'b0;
    pc             = '0;
    lif.load_valid = 1'b0;
    lif.load_byte  = 8'h00;
    lif.load_last  = 1'b0;
    repeat (2) step();
    reset = 1'b0;
    status("reset", 0, 1, 0, 0);
    fetch("reset_nop", 0, NOP);

    // Two-word program
    send(8'h12, 0);
    status("t1_b1", 0, 1, 0, 0);
    send(8'h34, 0);
    status("t1_w1", 0, 1, 0, 1);
    fetch("t1_gated", 0, NOP);
    send(8'hAB, 0);
    send(8'hCD, 1);
    end_program();
    status("t1_done", 1, 0, 0, 2);
    fetch("t1_pc0", 0, 16'h1234);
    fetch("t1_pc1", 1, 16'hABCD);
    fetch("t1_pc2", 2, NOP);
    fetch("t1_pc900", 10'd900, NOP);

    // Early end pads low byte
    do_reload();
    status("t2_reload", 0, 1, 0, 0);
    send(8'h12, 0);
    send(8'h56, 1);
    end_program();
    status("t2_done", 1, 0, 0, 1);
    fetch("t2_pc0", 0, 16'h1256);
    fetch("t2_pc1_stale", 1, NOP);
    do_reload();
    send(8'h77, 1);
    end_program();
    status("t2b_done", 1, 0, 0, 1);
    fetch("t2b_pc0", 0, 16'h7700);

    // Valid held low mid-word
    do_reload();
    send(8'hAB, 0);
    repeat (3) step();
    status("t3_hold", 0, 1, 0, 0);
    send(8'hCD, 0);
    status("t3_w1", 0, 1, 0, 1);
    send(8'h11, 1);
    end_program();
    status("t3_done", 1, 0, 0, 2);
    fetch("t3_pc0", 0, 16'hABCD);
    fetch("t3_pc1", 1, 16'h1100);

    // Reload ignored while loading
    do_reload();
    send(8'h12, 0);
    reload = 1'b1;
    step();
    reload = 1'b0;
    status("t3_rl_ign", 0, 1, 0, 0);
    send(8'h34, 1);
    end_program();
    status("t3_rl_done", 1, 0, 0, 1);
    fetch("t3_rl_pc0", 0, 16'h1234);

    // Overflow at DEPTH=4
    do_reload();
    for (int i = 1; i <= 8; i++) send(8'(i), 0);
    status("t4_ovf", 0, 0, 1, 4);
    lif.load_valid = 1'b1;
    lif.load_byte  = 8'h09;
    repeat (2) step();
    lif.load_valid = 1'b0;
    status("t4_bp", 0, 0, 1, 4);
    fetch("t4_nop", 0, NOP);
    do_reload();
    status("t4_reload", 0, 1, 0, 0);

    // Reset with reload and a valid byte in RUN
    send(8'h12, 0);
    send(8'h34, 1);
    end_program();
    status("t5_run", 1, 0, 0, 1);
    reset          = 1'b1;
    reload         = 1'b1;
    lif.load_valid = 1'b1;
    lif.load_byte  = 8'h55;
    lif.load_last  = 1'b1;
    step();
    reset          = 1'b0;
    reload         = 1'b0;
    lif.load_valid = 1'b0;
    lif.load_last  = 1'b0;
    tb_csum        = 8'h00;
    status("t5_reset", 0, 1, 0, 0);
    send(8'h66, 1);
    end_program();
    status("t5_done", 1, 0, 0, 1);
    fetch("t5_pc0", 0, 16'h6600);

`ifdef LOADER_CHECKSUM_EN
    do_reload();
    send(8'h12, 0);
    send(8'h34, 1);
    status("cs_check", 0, 1, 0, 1);
    send(8'h26, 0);
    tb_csum = 8'h00;
    status("cs_good", 1, 0, 0, 1);
    fetch("cs_pc0", 0, 16'h1234);
    do_reload();
    send(8'h12, 0);
    send(8'h34, 1);
    send(8'h27, 0);
    tb_csum = 8'h00;
    status("cs_bad", 0, 0, 1, 1);
`endif

    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
